keypad_scan_driver: RTL and testbench

- Active end of the 4x4 matrix keypad interface: drives one-cold column strobes, samples the active-low row lines and debounces the press and release.
- Emits one hex key code per physical press: a single-cycle valid pulse plus a held level.
- Sits between the keypad pins and the vending machine controller. It replaces the externally supplied column strobe, and its key code feeds the controller's key input.

---
 rtl/keypad_scan_driver.sv | 192 +++++++++++++++++++
 tb/tb_keypad_scan_driver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_driver.sv
// rtl/keypad_scan_driver.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Purpose: drives one-cold active-low column strobes across a 4x4 keypad,
// samples the active-low rows through a 2-flop synchroniser, debounces the
// press and the release of one key, and reports one hex code per press.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low
//   row[3:0]   keypad rows, active-low, pulled up; row[0] is the top row
//   col[3:0]   column drive, one-cold active-low; col[0] is the left column
//   key_code   hex code of the last accepted key (held until the next press)
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high from press acceptance until release acceptance
module keypad_scan_driver #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell_cnt, dwell_cnt_d;
  logic [BW-1:0] db_cnt, db_cnt_d;
  logic [1:0]    col_idx, col_idx_d;
  logic [1:0]    row_idx, row_idx_d;
  logic [3:0]    col_d;
  logic [3:0]    key_code_d;
  logic          key_valid_d;
  logic          key_held_d;
  logic          row_hit;
  logic [1:0]    low_row;
  logic [3:0]    key_lookup;

  // Rows are asynchronous to clk; both stages idle at "nothing pressed".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Lowest-indexed low row wins when several keys share the driven column.
  always_comb begin
    low_row = 2'd3;
    if (!row_sync[0])      low_row = 2'd0;
    else if (!row_sync[1]) low_row = 2'd1;
    else if (!row_sync[2]) low_row = 2'd2;
  end

  // The tracked key is still making contact.
  assign row_hit = ~row_sync[row_idx];

  always_comb begin
    key_lookup = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: key_lookup = 4'h1;
      4'b00_01: key_lookup = 4'h2;
      4'b00_10: key_lookup = 4'h3;
      4'b00_11: key_lookup = 4'hA;
      4'b01_00: key_lookup = 4'h4;
      4'b01_01: key_lookup = 4'h5;
      4'b01_10: key_lookup = 4'h6;
      4'b01_11: key_lookup = 4'hB;
      4'b10_00: key_lookup = 4'h7;
      4'b10_01: key_lookup = 4'h8;
      4'b10_10: key_lookup = 4'h9;
      4'b10_11: key_lookup = 4'hC;
      4'b11_00: key_lookup = 4'hE;
      4'b11_01: key_lookup = 4'h0;
      4'b11_10: key_lookup = 4'hF;
      4'b11_11: key_lookup = 4'hD;
      default:  key_lookup = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      col       <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      dwell_cnt <= dwell_cnt_d;
      db_cnt    <= db_cnt_d;
      col_idx   <= col_idx_d;
      row_idx   <= row_idx_d;
      col       <= col_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
    end
  end

  // col_idx stays put outside SCAN, which is what freezes the column while a
  // key is being debounced or held; leaving for SCAN always steps one column.
  always_comb begin
    state_d     = state;
    dwell_cnt_d = dwell_cnt;
    db_cnt_d    = db_cnt;
    col_idx_d   = col_idx;
    row_idx_d   = row_idx;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_held_d  = key_held;

    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt_d = '0;
          if (row_sync == 4'hF) begin
            col_idx_d = col_idx + 2'd1;
          end else begin
            row_idx_d = low_row;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!row_hit) begin
          state_d     = SCAN;
          col_idx_d   = col_idx + 2'd1;
          dwell_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d     = PRESSED;
          key_code_d  = key_lookup;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end

      PRESSED: begin
        if (!row_hit) begin
          db_cnt_d = '0;
          state_d  = RELEASE;
        end
      end

      RELEASE: begin
        if (row_hit) begin
          state_d = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          key_held_d  = 1'b0;
          state_d     = SCAN;
          col_idx_d   = col_idx + 2'd1;
          dwell_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase

    col_d = ~(4'b0001 << col_idx_d);
  end

endmodule

// File: tb/tb_keypad_scan_driver.sv
// tb/tb_keypad_scan_driver.sv - self-checking bench for keypad_scan_driver
module tb_keypad_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int LAT_MAX  = 4 * SCAN_DIV + 2 + DEB + 1;
  // 2 synchroniser stages, 1 cycle to notice the release, then DEB stable cycles
  localparam int REL_LAT  = 2 + 1 + DEB;
  localparam int BUDGET   = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  int          tests = 0;
  int          fails = 0;
  int          valid_cnt = 0;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_driver #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] onecold(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c] = 1'b0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) valid_cnt++;
  endtask

  task automatic wait_valid(input string tag, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < BUDGET) begin
      tick();
      n++;
      got = (key_valid === 1'b1);
    end
    check({tag, " valid seen"}, got, 1);
  endtask

  task automatic wait_held_low(input string tag, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < BUDGET) begin
      tick();
      n++;
      got = (key_held === 1'b0);
    end
    check({tag, " held cleared"}, got, 1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] target, input bit equal);
    int n;
    n = 0;
    while (((col === target) != equal) && n < BUDGET) begin
      tick();
      n++;
    end
    check(tag, (col === target), equal);
  endtask

  task automatic press_cycle(input int r, input int c, input int hold);
    int n;
    int v0;
    int idx;
    idx = r * 4 + c;
    v0 = valid_cnt;
    pressed[idx] = 1'b1;
    wait_valid("press", n);
    check("press latency within bound", (n <= LAT_MAX), 1);
    check("press code", key_code, kmap[idx]);
    check("press held", key_held, 1);
    tick();
    check("valid one cycle", key_valid, 0);
    repeat (hold) tick();
    check("col frozen", col, onecold(c));
    check("still held", key_held, 1);
    check("single valid", valid_cnt - v0, 1);
    pressed[idx] = 1'b0;
    wait_held_low("release", n);
    check("release latency", n, REL_LAT);
    check("scan resumes next col", col, onecold((c + 1) % 4));
    check("code kept after release", key_code, kmap[idx]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v0;
    logic [3:0] code0;

    reset   = 1'b0;
    pressed = 16'h0;
    repeat (3) tick();
    check("reset col", col, 4'b1110);
    check("reset key_code", key_code, 4'h0);
    check("reset key_valid", key_valid, 0);
    check("reset key_held", key_held, 0);
    reset = 1'b1;

    // Idle rotation: column index advances every SCAN_DIV cycles.
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("idle col", col, onecold((k / SCAN_DIV) % 4));
      check("idle valid", key_valid, 0);
      check("idle held", key_held, 0);
    end

    // "9" held for a long time
    press_cycle(2, 2, 200);

    // random single presses
    repeat (6) begin
      press_cycle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(5, 40));
    end

    // short glitches on random keys
    repeat (4) begin
      int r, c, len;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      len = $urandom_range(1, 3);
      code0 = key_code;
      v0 = valid_cnt;
      wait_col("glitch col leave", onecold(c), 1'b0);
      wait_col("glitch col reach", onecold(c), 1'b1);
      pressed[r*4+c] = 1'b1;
      repeat (len) tick();
      pressed[r*4+c] = 1'b0;
      repeat (20) tick();
      check("glitch no valid", valid_cnt - v0, 0);
      check("glitch code kept", key_code, code0);
      check("glitch not held", key_held, 0);
      wait_col("glitch scan resumes", onecold((c + 1) % 4), 1'b1);
    end

    // release bounce on "C"
    v0 = valid_cnt;
    pressed[11] = 1'b1;
    wait_valid("bounce", n);
    check("bounce code", key_code, 4'hC);
    repeat ($urandom_range(2, 5)) begin
      pressed[11] = 1'b0;
      repeat ($urandom_range(1, 5)) begin
        tick();
        check("bounce held hi", key_held, 1);
      end
      pressed[11] = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        tick();
        check("bounce held lo", key_held, 1);
      end
    end
    pressed[11] = 1'b0;
    wait_held_low("bounce release", n);
    check("bounce release latency", n, REL_LAT);
    check("bounce single valid", valid_cnt - v0, 1);
    check("bounce code kept", key_code, 4'hC);

    // same-column pair "4"+"E", then "F" in another column while held
    pressed[4]  = 1'b1;
    pressed[12] = 1'b1;
    wait_valid("pair", n);
    check("pair lowest row wins", key_code, 4'h4);
    v0 = valid_cnt;
    pressed[14] = 1'b1;
    repeat (60) tick();
    check("second key ignored", valid_cnt - v0, 0);
    check("pair col frozen", col, onecold(0));
    pressed[4]  = 1'b0;
    pressed[12] = 1'b0;
    wait_held_low("pair release", n);
    check("pair release latency", n, REL_LAT);
    check("no valid before release", valid_cnt - v0, 0);
    wait_valid("second key", n);
    check("second key code", key_code, 4'hF);
    check("second key one valid", valid_cnt - v0, 1);
    check("second key col", col, onecold(2));
    pressed[14] = 1'b0;
    wait_held_low("second key release", n);

    // reset while "D" is pressed
    pressed[15] = 1'b1;
    wait_valid("pre-reset", n);
    check("pre-reset code", key_code, 4'hD);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("mid reset col", col, 4'b1110);
    check("mid reset code", key_code, 4'h0);
    check("mid reset held", key_held, 0);
    check("mid reset valid", key_valid, 0);
    repeat (3) tick();
    reset = 1'b1;
    v0 = valid_cnt;
    wait_valid("post-reset", n);
    check("post-reset code", key_code, 4'hD);
    check("post-reset latency within bound", (n <= LAT_MAX), 1);
    check("post-reset one valid", valid_cnt - v0, 1);
    pressed[15] = 1'b0;
    wait_held_low("post-reset release", n);
    check("post-reset release latency", n, REL_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
